// File: rtl/pixel_frame_store.sv
// pixel_frame_store: (x,y,color) pixel writes into an on-chip frame RAM plus a 2-cycle raster read port.
// Define FRAME_STORE_CLEAR_EN to sweep the whole RAM to BG_COLOR after every reset.
module pixel_frame_store #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int X_BITS = 8,
  parameter int Y_BITS = 7,
  parameter int COLOR_BITS = 3,
  parameter logic [COLOR_BITS-1:0] BG_COLOR = '0
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic [X_BITS-1:0]     wr_x,
  input  logic [Y_BITS-1:0]     wr_y,
  input  logic [COLOR_BITS-1:0] wr_color,
  input  logic                  wr_enable,
  input  logic [X_BITS-1:0]     rd_x,
  input  logic [Y_BITS-1:0]     rd_y,
  input  logic                  rd_req,
  output logic [COLOR_BITS-1:0] rd_color,
  output logic                  rd_valid,
  output logic                  busy,
  output logic [7:0]            drop_count
);

  localparam int DEPTH = SCR_W * SCR_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(SCR_W);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [COLOR_BITS-1:0] color_t;

  function automatic addr_t lin(input logic [X_BITS-1:0] x,
                                input logic [Y_BITS-1:0] y);
    return ADDR_W'(y) * W_A + ADDR_W'(x);
  endfunction

  logic   wr_enable_d_q, wr_enable_d_d;
  logic   w1_vld_q, w1_vld_d;
  addr_t  w1_addr_q, w1_addr_d;
  color_t w1_color_q, w1_color_d;
  logic   w2_vld_q, w2_vld_d;
  addr_t  w2_addr_q, w2_addr_d;
  color_t w2_color_q, w2_color_d;
  logic   [7:0] drop_q, drop_d;

  logic   r1_vld_q, r1_vld_d;
  logic   r1_bg_q, r1_bg_d;
  addr_t  r1_addr_q, r1_addr_d;
  logic   r2_vld_q, r2_vld_d;
  logic   r2_bg_q, r2_bg_d;
  logic   r2_byp_q, r2_byp_d;
  color_t r2_byp_color_q, r2_byp_color_d;
  logic   rd_valid_q, rd_valid_d;
  color_t rd_color_q, rd_color_d;

  logic   wr_edge, wr_in_rng, wr_ok, rd_in_rng;
  logic   busy_w, clr_we;
  addr_t  clr_addr;
  logic   mem_we;
  addr_t  mem_waddr;
  color_t mem_wdata;
  color_t ram_rd_q;
  color_t mem [DEPTH];

`ifdef FRAME_STORE_CLEAR_EN
  localparam addr_t LAST_A = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;
  state_e state_q, state_d;
  addr_t  clr_cnt_q, clr_cnt_d;

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_A) state_d = S_RUN;
      end
      S_RUN: state_d = S_RUN;
    endcase
  end

  always_comb begin
    busy_w   = (state_q == S_CLEAR);
    clr_we   = busy_w && Reset;
    clr_addr = clr_cnt_q;
  end
`else
  assign busy_w   = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  always_comb begin
    wr_in_rng     = (int'(wr_x) < SCR_W) && (int'(wr_y) < SCR_H);
    wr_edge       = wr_enable && !wr_enable_d_q;
    wr_ok         = wr_in_rng && !busy_w;
    wr_enable_d_d = wr_enable;
    w1_vld_d      = wr_edge && wr_ok;
    w1_addr_d     = lin(wr_x, wr_y);
    w1_color_d    = wr_color;
    w2_vld_d      = w1_vld_q;
    w2_addr_d     = w1_addr_q;
    w2_color_d    = w1_color_q;
    drop_d        = drop_q;
    if (wr_edge && !wr_ok && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;

    rd_in_rng = (int'(rd_x) < SCR_W) && (int'(rd_y) < SCR_H);
    r1_vld_d  = rd_req;
    r1_bg_d   = !rd_in_rng || busy_w;
    r1_addr_d = rd_in_rng ? lin(rd_x, rd_y) : '0;
    r2_vld_d  = r1_vld_q;
    r2_bg_d   = r1_bg_q;
    // RAM read sees old data when W2 commits the same address on this edge
    r2_byp_d       = w2_vld_q && (w2_addr_q == r1_addr_q);
    r2_byp_color_d = w2_color_q;
    rd_valid_d     = r2_vld_q;
    rd_color_d     = r2_bg_q  ? BG_COLOR :
                     r2_byp_q ? r2_byp_color_q : ram_rd_q;
  end

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      wr_enable_d_q <= 1'b0;
      w1_vld_q      <= 1'b0;
      w2_vld_q      <= 1'b0;
      r1_vld_q      <= 1'b0;
      r2_vld_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_color_q    <= '0;
      drop_q        <= '0;
    end else begin
      wr_enable_d_q <= wr_enable_d_d;
      w1_vld_q      <= w1_vld_d;
      w2_vld_q      <= w2_vld_d;
      r1_vld_q      <= r1_vld_d;
      r2_vld_q      <= r2_vld_d;
      rd_valid_q    <= rd_valid_d;
      rd_color_q    <= rd_color_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge Clck) begin
    w1_addr_q      <= w1_addr_d;
    w1_color_q     <= w1_color_d;
    w2_addr_q      <= w2_addr_d;
    w2_color_q     <= w2_color_d;
    r1_bg_q        <= r1_bg_d;
    r1_addr_q      <= r1_addr_d;
    r2_bg_q        <= r2_bg_d;
    r2_byp_q       <= r2_byp_d;
    r2_byp_color_q <= r2_byp_color_d;
  end

  always_comb begin
    mem_we    = Reset && (clr_we || w2_vld_q);
    mem_waddr = clr_we ? clr_addr : w2_addr_q;
    mem_wdata = clr_we ? BG_COLOR : w2_color_q;
  end

  always_ff @(posedge Clck) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_rd_q <= mem[r1_addr_q];
  end

  assign rd_color   = rd_color_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_w;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_frame_store.sv
// tb_pixel_frame_store: directed checks of write capture, drops, read latency and bypass.
// Define FRAME_STORE_CLEAR_EN for both bench and RTL to exercise the clear sweep.
module tb_pixel_frame_store;

  localparam int X_BITS = 8;
  localparam int Y_BITS = 7;
  localparam int DEPTH = 160 * 120;
  localparam logic [2:0] BG = 3'b000;
`ifdef FRAME_STORE_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic              Clck = 1'b0;
  logic              Reset;
  logic [X_BITS-1:0] wr_x, rd_x;
  logic [Y_BITS-1:0] wr_y, rd_y;
  logic [2:0]        wr_color, rd_color;
  logic              wr_enable, rd_req, rd_valid, busy;
  logic [7:0]        drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_drop = 0;
  int n;

  pixel_frame_store dut (
    .Clck(Clck), .Reset(Reset),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_enable(wr_enable),
    .rd_x(rd_x), .rd_y(rd_y), .rd_req(rd_req),
    .rd_color(rd_color), .rd_valid(rd_valid),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 Clck = ~Clck;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clck);
    @(negedge Clck);
  endtask

  task automatic wr_px(input int x, input int y, input logic [2:0] c);
    wr_x = X_BITS'(x); wr_y = Y_BITS'(y); wr_color = c;
    wr_enable = 1'b1; step();
    wr_enable = 1'b0; step(); step();
  endtask

  task automatic rd_px(input string tag, input int x, input int y,
                       input logic [2:0] exp);
    rd_x = X_BITS'(x); rd_y = Y_BITS'(y); rd_req = 1'b1; step();
    rd_req = 1'b0; step();
    check({tag, "_early"}, rd_valid, 0);
    step();
    check({tag, "_vld"}, rd_valid, 1);
    check({tag, "_col"}, rd_color, exp);
    step();
    check({tag, "_pulse"}, rd_valid, 0);
  endtask

  initial begin
    Reset = 1'b0; rd_req = 1'b0; rd_x = '0; rd_y = '0;
    wr_x = 8'd1; wr_y = 7'd1; wr_color = 3'b101; wr_enable = 1'b1;
    @(negedge Clck);
    step();
    check("rst_vld", rd_valid, 0);
    check("rst_col", rd_color, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", busy, CLR);

    // wr_enable already high on the first cycle out of reset
    n = busy ? 1 : 0;
    Reset = 1'b1; step();
    wr_enable = 1'b0;
    while (busy === 1'b1 && n < 25000) begin
      n++;
      step();
    end
    check("busy_cycles", n, CLR ? DEPTH : 0);
    check("busy_end", busy, 0);
    exp_drop = CLR ? 1 : 0;
    check("first_drop", drop_count, exp_drop);
    rd_px("first", 1, 1, CLR ? BG : 3'b101);
    if (CLR) rd_px("clr_corner", 159, 119, BG);

    // held enable: one write only, later color ignored
    wr_x = 8'd5; wr_y = 7'd3; wr_color = 3'b110; wr_enable = 1'b1;
    step();
    wr_color = 3'b011; step(); step();
    wr_enable = 1'b0; step(); step();
    rd_px("hold", 5, 3, 3'b110);
    check("hold_drop", drop_count, exp_drop);

    wr_px(160, 0, 3'b111);
    wr_px(0, 120, 3'b111);
    exp_drop += 2;
    check("oor_drop", drop_count, exp_drop);
    wr_px(159, 119, 3'b111);
    check("edge_drop", drop_count, exp_drop);
    rd_px("edge", 159, 119, 3'b111);
    rd_px("oor_rd", 200, 5, BG);

    // write accepted at N, read sampled at N+1 must see it
    wr_px(10, 10, 3'b100);
    rd_px("byp_pre", 10, 10, 3'b100);
    wr_x = 8'd10; wr_y = 7'd10; wr_color = 3'b001; wr_enable = 1'b1;
    step();
    wr_enable = 1'b0;
    rd_px("byp", 10, 10, 3'b001);

    for (int i = 0; i < 8; i++) wr_px(i, 0, 3'(i));
    for (int t = 0; t < 12; t++) begin
      check("burst_vld", rd_valid, (t >= 3 && t <= 10) ? 1 : 0);
      if (t >= 3 && t <= 10) check("burst_col", rd_color, t - 3);
      rd_req = (t < 8);
      rd_x = X_BITS'(t); rd_y = '0;
      step();
    end

    for (int i = 0; i < 251; i++) wr_px(200, 0, 3'b000);
    check("drop_253", drop_count, exp_drop + 251);
    for (int i = 0; i < 49; i++) wr_px(200, 0, 3'b000);
    check("drop_sat", drop_count, 255);

`ifndef FRAME_STORE_CLEAR_EN
    wr_px(20, 20, 3'b010);
    rd_px("rst_pre", 20, 20, 3'b010);
    wr_x = 8'd20; wr_y = 7'd20; wr_color = 3'b101; wr_enable = 1'b1;
    rd_x = 8'd20; rd_y = 7'd20; rd_req = 1'b1;
    step();
    wr_enable = 1'b0; rd_req = 1'b0; Reset = 1'b0;
    step();
    check("mid_vld0", rd_valid, 0);
    check("mid_drop", drop_count, 0);
    Reset = 1'b1; step();
    check("mid_vld1", rd_valid, 0);
    step();
    check("mid_vld2", rd_valid, 0);
    rd_px("mid_ram", 20, 20, 3'b010);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_frame_store.md
# pixel_frame_store

Frame-buffer endpoint for the pixel write stream produced by the board/chess painting logic: accepts (x, y, color, enable-pulse) pixel writes, maps them to a linear address and stores them in an on-chip RAM. A second, independent read port serves the raster/VGA scanner with fixed two-cycle latency. Sits between the painter and the display output, on the same clock.

## Interface
- SCR_W, 160: screen width in pixels
- SCR_H, 120: screen height in pixels
- X_BITS, 8: x coordinate width
- Y_BITS, 7: y coordinate width
- COLOR_BITS, 3: pixel color width
- BG_COLOR, 3'b000: background color (clear value)

- Clck  input  1  clock, all logic on posedge
- Reset  input  1  reset, synchronous, active-low
- wr_x  input  X_BITS  write x coordinate
- wr_y  input  Y_BITS  write y coordinate
- wr_color  input  COLOR_BITS  write color
- wr_enable  input  1  write strobe, level; one write per rising edge
- rd_x  input  X_BITS  read x coordinate
- rd_y  input  Y_BITS  read y coordinate
- rd_req  input  1  read request, sampled every cycle
- rd_color  output  COLOR_BITS  read data
- rd_valid  output  1  rd_color valid, one-cycle pulse per request
- busy  output  1  clear sweep in progress
- drop_count  output  8  saturating count of rejected writes

## Operation
- Address = y*SCR_W + x; depth SCR_W*SCR_H (19200 default); address width ceil(log2(depth)).
- Write capture: register wr_enable_d; accept when wr_enable=1 and wr_enable_d=0. Holding wr_enable high for N cycles yields exactly one write. x,y,color sampled on the accepting cycle.
- Range check: x >= SCR_W or y >= SCR_H -> write dropped, drop_count += 1 (saturates at 255).
- Write pipeline: W1 (edge detect, range check, address multiply registered) -> W2 (RAM write).
- Read pipeline: R1 (address registered) -> R2 (RAM read, rd_color/rd_valid registered). Out-of-range read returns BG_COLOR, rd_valid still asserted.
- Bypass: if W2 writes the address R2 reads in the same cycle, rd_color = new write data.
- States: CLEAR (only with CLEAR_EN) -> RUN. RUN is permanent until reset.

## Timing
- Reset values: rd_color=0, rd_valid=0, drop_count=0, wr_enable_d=0, busy=1 with FRAME_STORE_CLEAR_EN else 0; W1/R1 pipeline valids cleared.
- Write latency: accepting edge N -> RAM updated at edge N+2; a read requested at edge N+1 or later to the same address returns new data.
- Read latency: rd_req sampled at edge N -> rd_valid=1 after edge N+2 for one cycle; back-to-back requests give back-to-back valids (throughput 1/cycle).
- Simultaneous write and read: both proceed; no stall, no backpressure.
- Reset mid-operation: in-flight W1/R1/R2 entries squashed (no write, no rd_valid); RAM contents retained without CLEAR_EN.
- wr_enable high in first cycle after reset counts as a rising edge.

## Configuration
- FRAME_STORE_CLEAR_EN defined: after reset enter CLEAR; counter sweeps address 0..depth-1, writing BG_COLOR one per cycle; busy=1 for exactly depth cycles, then RUN. Write edges during CLEAR are dropped and counted in drop_count. Reads during CLEAR are serviced and return BG_COLOR.
- Undefined: no CLEAR state, busy tied 0, RAM contents undefined after power-up and unchanged by reset.

## Test plan
- Write (x=5,y=3,color=3'b110) with wr_enable held 3 cycles, read (5,3) after -> rd_color=3'b110, rd_valid 1 cycle, exactly one RAM write, drop_count=0.
- Write (x=160,y=0) then (x=0,y=120) -> both dropped, drop_count=2; 300 out-of-range writes -> drop_count=255.
- Write (10,10)=3'b001 at edge N, rd_req (10,10) at edge N+1 -> rd_valid at N+3 with 3'b001 (bypass/ordering).
- Read requests every cycle for 8 cycles to (0..7,0) -> 8 consecutive rd_valid pulses, first at 2 cycles after first request, data in request order.
- CLEAR_EN: reset, check busy=1 for 19200 cycles, write edge during CLEAR -> drop_count=1; after busy falls read (159,119) -> BG_COLOR.
- Reset asserted one cycle after an accepted write -> RAM at that address unchanged (no CLEAR_EN), rd_valid=0, drop_count=0.
